// File: rtl/alu_instr_encoder_if.sv
// Bus between a test-program loader and the ALU instruction encoder.
// Carries the command handshake and the imem write port with its status outputs.
//   master : loader side, drives command fields, observes write port and status
//   slave  : encoder side, consumes commands, drives write port and status
interface alu_instr_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        alu_ctrl;
    logic              is_imm;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [11:0]       imm;
    logic              seal;
    logic              clear;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W-1:0] wr_count;
    logic              full;
    logic              sealed;
    logic              cmd_err;
    logic [7:0]        err_cnt;

    modport master (
        output cmd_valid, alu_ctrl, is_imm, rd, rs1, rs2, imm, seal, clear,
        input  cmd_ready, imem_we, imem_addr, imem_wdata, wr_count, full,
               sealed, cmd_err, err_cnt
    );

    modport slave (
        input  cmd_valid, alu_ctrl, is_imm, rd, rs1, rs2, imm, seal, clear,
        output cmd_ready, imem_we, imem_addr, imem_wdata, wr_count, full,
               sealed, cmd_err, err_cnt
    );
endinterface

// File: rtl/alu_instr_encoder.sv
// ALU instruction encoder: converts ALU operation requests into RV32I R-type /
// I-type instruction words and writes them sequentially into imem. A seal
// command appends a halt loop (beq x0,x0,0) and parks the encoder.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bus   : slave side of alu_instr_encoder_if (command handshake, seal/clear,
//           imem write strobe/address/data, wr_count, full, sealed, cmd_err, err_cnt)
module alu_instr_encoder #(
    parameter int ADDR_W = 6
) (
    input logic                 clk,
    input logic                 reset,
    alu_instr_encoder_if.slave  bus
);
    localparam logic [31:0] HALT_WORD = 32'h0000_0063;
    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;

    typedef enum logic [1:0] {IDLE, WRITE, HALT_WR, SEALED} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic              full;
    logic              accept;
    logic              encodable;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [31:0]       word;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Decode ALUControl into funct fields; SUB has no immediate form.
    always_comb begin
        f3        = 3'b000;
        f7        = 7'b0000000;
        encodable = 1'b1;
        case (bus.alu_ctrl)
            3'b000: f3 = 3'b000;
            3'b001: begin
                f3        = 3'b000;
                f7        = 7'b0100000;
                encodable = !bus.is_imm;
            end
            3'b010: f3 = 3'b111;
            3'b011: f3 = 3'b110;
            3'b101: f3 = 3'b010;
            default: encodable = 1'b0;
        endcase
        word = bus.is_imm ? {bus.imm, bus.rs1, f3, bus.rd, OP_I}
                          : {f7, bus.rs2, bus.rs1, f3, bus.rd, OP_R};
    end

    // Last slot is reserved for the halt word.
    assign full          = (wr_ptr == {ADDR_W{1'b1}});
    assign bus.cmd_ready = (state == IDLE) && !full && !bus.clear;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    // Combinational strobe so clear aborts an in-flight write and reset drops it at once.
    assign bus.imem_we   = ((state == WRITE) || (state == HALT_WR)) && !bus.clear;
    assign bus.sealed    = (state == SEALED);
    assign bus.full      = full;
    assign bus.wr_count  = wr_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            bus.err_cnt    <= '0;
            bus.cmd_err    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
        end else begin
            bus.cmd_err <= 1'b0;
            if (bus.clear) begin
                state       <= IDLE;
                wr_ptr      <= '0;
                bus.err_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            if (encodable) begin
                                bus.imem_addr  <= wr_ptr;
                                bus.imem_wdata <= word;
                                state          <= WRITE;
                            end else begin
                                bus.cmd_err <= 1'b1;
                                bus.err_cnt <= sat_inc8(bus.err_cnt);
                            end
                        end else if (bus.seal) begin
                            bus.imem_addr  <= wr_ptr;
                            bus.imem_wdata <= HALT_WORD;
                            state          <= HALT_WR;
                        end
                    end
                    WRITE: begin
                        wr_ptr <= wr_ptr + 1'b1;
                        state  <= IDLE;
                    end
                    HALT_WR: begin
                        // Sealing from the last slot leaves the pointer there instead of wrapping.
                        if (!full) wr_ptr <= wr_ptr + 1'b1;
                        state <= SEALED;
                    end
                    SEALED: state <= SEALED;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_instr_encoder.sv
module tb_alu_instr_encoder;
    localparam int ADDR_W = 2;

    logic clk = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    alu_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    alu_instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [2:0] ctrl, input logic imm_f, input logic [4:0] rd_v,
                         input logic [4:0] rs1_v, input logic [4:0] rs2_v, input logic [11:0] imm_v);
        bus.alu_ctrl  = ctrl;
        bus.is_imm    = imm_f;
        bus.rd        = rd_v;
        bus.rs1       = rs1_v;
        bus.rs2       = rs2_v;
        bus.imm       = imm_v;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        compared++; if (bus.imem_we !== 1'b0) begin mismatched++; $display("FAIL rst_we got %0b want 0", bus.imem_we); end
        compared++; if (bus.imem_addr !== 2'd0) begin mismatched++; $display("FAIL rst_addr got %0d want 0", bus.imem_addr); end
        compared++; if (bus.imem_wdata !== 32'h0) begin mismatched++; $display("FAIL rst_wdata got %h want 0", bus.imem_wdata); end
        compared++; if (bus.wr_count !== 2'd0) begin mismatched++; $display("FAIL rst_wr_count got %0d want 0", bus.wr_count); end
        compared++; if (bus.err_cnt !== 8'd0) begin mismatched++; $display("FAIL rst_err_cnt got %0d want 0", bus.err_cnt); end
        compared++; if (bus.sealed !== 1'b0 || bus.cmd_err !== 1'b0 || bus.full !== 1'b0) begin
            mismatched++; $display("FAIL rst_flags got sealed=%0b cmd_err=%0b full=%0b want 0 0 0", bus.sealed, bus.cmd_err, bus.full); end
        @(posedge clk); #1;
        reset = 1'b0;
        compared++; if (bus.cmd_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready got %0b want 1", bus.cmd_ready); end
    endtask

    task automatic test_rtype();
        issue(3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        compared++; if (bus.imem_we !== 1'b1) begin mismatched++; $display("FAIL add_we got %0b want 1", bus.imem_we); end
        compared++; if (bus.imem_addr !== 2'd0) begin mismatched++; $display("FAIL add_addr got %0d want 0", bus.imem_addr); end
        compared++; if (bus.imem_wdata !== 32'h002081B3) begin mismatched++; $display("FAIL add_wdata got %h want 002081b3", bus.imem_wdata); end
        @(posedge clk); #1;
        compared++; if (bus.imem_we !== 1'b0) begin mismatched++; $display("FAIL add_we_drop got %0b want 0", bus.imem_we); end
        compared++; if (bus.wr_count !== 2'd1) begin mismatched++; $display("FAIL add_count got %0d want 1", bus.wr_count); end
        compared++; if (bus.imem_wdata !== 32'h002081B3) begin mismatched++; $display("FAIL add_hold got %h want 002081b3", bus.imem_wdata); end
    endtask

    task automatic test_encodings();
        logic [2:0]  c  [5] = '{3'b001, 3'b000, 3'b011, 3'b101, 3'b010};
        logic        ii [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [4:0]  d  [5] = '{5'd5, 5'd1, 5'd2, 5'd4, 5'd8};
        logic [4:0]  s1 [5] = '{5'd6, 5'd0, 5'd1, 5'd1, 5'd9};
        logic [4:0]  s2 [5] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd10};
        logic [11:0] im [5] = '{12'h000, 12'h005, 12'h0FF, 12'hFFF, 12'h000};
        logic [31:0] ex [5] = '{32'h407302B3, 32'h00500093, 32'h0FF0E113, 32'hFFF0A213, 32'h00A4F433};
        for (int i = 0; i < 5; i++) begin
            do_clear();
            issue(c[i], ii[i], d[i], s1[i], s2[i], im[i]);
            compared++; if (bus.imem_we !== 1'b1 || bus.imem_wdata !== ex[i]) begin
                mismatched++; $display("FAIL enc_%0d got we=%0b wdata=%h want we=1 wdata=%h", i, bus.imem_we, bus.imem_wdata, ex[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_errors();
        do_clear();
        issue(3'b111, 1'b0, 5'd1, 5'd1, 5'd1, 12'd0);
        compared++; if (bus.cmd_err !== 1'b1 || bus.imem_we !== 1'b0) begin
            mismatched++; $display("FAIL err1 got cmd_err=%0b we=%0b want 1 0", bus.cmd_err, bus.imem_we); end
        issue(3'b001, 1'b1, 5'd1, 5'd1, 5'd0, 12'd1);
        compared++; if (bus.cmd_err !== 1'b1 || bus.imem_we !== 1'b0) begin
            mismatched++; $display("FAIL err_subi got cmd_err=%0b we=%0b want 1 0", bus.cmd_err, bus.imem_we); end
        compared++; if (bus.err_cnt !== 8'd2) begin mismatched++; $display("FAIL err_cnt2 got %0d want 2", bus.err_cnt); end
        @(posedge clk); #1;
        compared++; if (bus.cmd_err !== 1'b0) begin mismatched++; $display("FAIL err_pulse got %0b want 0", bus.cmd_err); end
        compared++; if (bus.wr_count !== 2'd0) begin mismatched++; $display("FAIL err_count got %0d want 0", bus.wr_count); end
        for (int i = 0; i < 260; i++) issue(3'b100, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0);
        compared++; if (bus.err_cnt !== 8'd255) begin mismatched++; $display("FAIL err_sat got %0d want 255", bus.err_cnt); end
        do_clear();
        compared++; if (bus.err_cnt !== 8'd0) begin mismatched++; $display("FAIL err_clear got %0d want 0", bus.err_cnt); end
    endtask

    task automatic test_full();
        int we_seen;
        do_clear();
        for (int i = 0; i < 3; i++) begin
            issue(3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 12'd0);
            @(posedge clk); #1;
        end
        compared++; if (bus.full !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            mismatched++; $display("FAIL full_flag got full=%0b ready=%0b want 1 0", bus.full, bus.cmd_ready); end
        compared++; if (bus.wr_count !== 2'd3) begin mismatched++; $display("FAIL full_count got %0d want 3", bus.wr_count); end
        bus.cmd_valid = 1'b1;
        bus.seal      = 1'b1;
        @(posedge clk); #1;
        bus.seal = 1'b0;
        compared++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 2'd3 || bus.imem_wdata !== 32'h00000063) begin
            mismatched++; $display("FAIL halt_wr got we=%0b addr=%0d wdata=%h want 1 3 00000063", bus.imem_we, bus.imem_addr, bus.imem_wdata); end
        @(posedge clk); #1;
        compared++; if (bus.sealed !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            mismatched++; $display("FAIL sealed got sealed=%0b ready=%0b want 1 0", bus.sealed, bus.cmd_ready); end
        we_seen = 0;
        bus.seal = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus.imem_we === 1'b1) we_seen++;
            @(posedge clk); #1;
        end
        bus.seal      = 1'b0;
        bus.cmd_valid = 1'b0;
        compared++; if (we_seen !== 0 || bus.sealed !== 1'b1) begin
            mismatched++; $display("FAIL sealed_hold got writes=%0d sealed=%0b want 0 1", we_seen, bus.sealed); end
        do_clear();
    endtask

    task automatic test_races();
        do_clear();
        bus.seal = 1'b1;
        issue(3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0);
        bus.seal = 1'b0;
        compared++; if (bus.imem_we !== 1'b1 || bus.imem_wdata !== 32'h002081B3) begin
            mismatched++; $display("FAIL race_cmd got we=%0b wdata=%h want 1 002081b3", bus.imem_we, bus.imem_wdata); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        compared++; if (bus.imem_we !== 1'b0 || bus.sealed !== 1'b0 || bus.wr_count !== 2'd1) begin
            mismatched++; $display("FAIL race_nohalt got we=%0b sealed=%0b count=%0d want 0 0 1", bus.imem_we, bus.sealed, bus.wr_count); end
        issue(3'b001, 1'b0, 5'd5, 5'd6, 5'd7, 12'd0);
        bus.clear = 1'b1;
        #1;
        compared++; if (bus.imem_we !== 1'b0) begin mismatched++; $display("FAIL clear_abort got we=%0b want 0", bus.imem_we); end
        @(posedge clk); #1;
        bus.clear = 1'b0;
        #1;
        compared++; if (bus.wr_count !== 2'd0 || bus.cmd_ready !== 1'b1) begin
            mismatched++; $display("FAIL clear_state got count=%0d ready=%0b want 0 1", bus.wr_count, bus.cmd_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        do_clear();
        issue(3'b110, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0);
        bus.seal = 1'b1;
        @(posedge clk); #1;
        bus.seal = 1'b0;
        compared++; if (bus.imem_we !== 1'b1 || bus.imem_wdata !== 32'h00000063 || bus.err_cnt !== 8'd1) begin
            mismatched++; $display("FAIL pre_reset got we=%0b wdata=%h err_cnt=%0d want 1 00000063 1", bus.imem_we, bus.imem_wdata, bus.err_cnt); end
        #2;
        reset = 1'b1;
        #1;
        compared++; if (bus.imem_we !== 1'b0) begin mismatched++; $display("FAIL areset_we got %0b want 0", bus.imem_we); end
        compared++; if (bus.imem_wdata !== 32'h0 || bus.imem_addr !== 2'd0) begin
            mismatched++; $display("FAIL areset_bus got addr=%0d wdata=%h want 0 0", bus.imem_addr, bus.imem_wdata); end
        compared++; if (bus.err_cnt !== 8'd0 || bus.wr_count !== 2'd0) begin
            mismatched++; $display("FAIL areset_cnt got err_cnt=%0d count=%0d want 0 0", bus.err_cnt, bus.wr_count); end
        @(posedge clk); #1;
        compared++; if (bus.sealed !== 1'b0) begin mismatched++; $display("FAIL areset_sealed got %0b want 0", bus.sealed); end
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.alu_ctrl  = 3'b000;
        bus.is_imm    = 1'b0;
        bus.rd        = 5'd0;
        bus.rs1       = 5'd0;
        bus.rs2       = 5'd0;
        bus.imm       = 12'd0;
        bus.seal      = 1'b0;
        bus.clear     = 1'b0;
        test_reset();
        test_rtype();
        test_encodings();
        test_errors();
        test_full();
        test_races();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
